// File: rtl/bus_reader.sv
// bus_reader: receive-side endpoint of the shared tri-stated data/tag bus.
// Samples the bus only while bus_valid is high, filters on tag, buffers
// accepted words in a circular FIFO and presents them over valid/ready.
// Keeps a sticky overflow flag and a saturating drop counter.
module bus_reader #(
    parameter int         DEPTH      = 4,
    parameter logic [1:0] MY_TAG     = 2'b01,
    parameter bit         ACCEPT_ALL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              bus_data,
    input  logic [1:0]               bus_tag,
    input  logic                     bus_valid,
    output logic                     bus_stall,
    output logic [63:0]              out_data,
    output logic [1:0]               out_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [63:0]   mem_data [DEPTH];
    logic [1:0]    mem_tag  [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          full, match, push, pop, drop;

    // bus_valid gates the tag compare, so a floated tag with bus_valid=0
    // resolves to no match and never reaches any state.
    assign full      = (level == LW'(DEPTH));
    assign match     = bus_valid && (ACCEPT_ALL || (bus_tag == MY_TAG));
    assign out_valid = (level != '0);
    assign bus_stall = full;
    assign pop       = out_valid && out_ready;
    assign push      = match && (!full || pop);
    assign drop      = match && full && !pop;

    // Head of FIFO is always visible; stable while not popped.
    assign out_data  = mem_data[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];

    // Storage write; cleared on reset so the head reads 0 afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
            end
        end else if (push) begin
            mem_data[wr_ptr] <= bus_data;
            mem_tag[wr_ptr]  <= bus_tag;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at power-of-2 DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                level <= level + LW'(1);
            else if (pop && !push)
                level <= level - LW'(1);
        end
    end

    // Overflow diagnostics; a clear in the same cycle as a drop wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_bus_reader.sv
// tb_bus_reader: directed vectors with a scoreboard queue; a negedge monitor
// pops expected words whenever the DUT completes a handshake.
module tb_bus_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] bus_data;
    logic [1:0]  bus_tag;
    logic        bus_valid;
    logic        bus_stall;
    logic [63:0] out_data;
    logic [1:0]  out_tag;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        clear_overflow;
    logic [7:0]  drop_count;
    logic [2:0]  level;

    int n_vec = 0;
    int n_err = 0;
    logic [65:0] exp_q[$];

    bus_reader #(.DEPTH(4), .MY_TAG(2'b01), .ACCEPT_ALL(1'b0)) dut (
        .clk(clk), .rst(rst),
        .bus_data(bus_data), .bus_tag(bus_tag), .bus_valid(bus_valid),
        .bus_stall(bus_stall),
        .out_data(out_data), .out_tag(out_tag), .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow(overflow), .clear_overflow(clear_overflow),
        .drop_count(drop_count), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [63:0] d);
        bus_valid = v;
        bus_tag   = t;
        bus_data  = d;
    endtask

    task automatic idle_bus();
        bus_valid = 1'b0;
        bus_tag   = 'z;
        bus_data  = 'z;
    endtask

    // Monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pop: got %0h expected none", out_data);
            end else begin
                logic [65:0] e;
                e = exp_q.pop_front();
                chk("pop_data", out_data, e[63:0]);
                chk("pop_tag", {62'd0, out_tag}, {62'd0, e[65:64]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] tags [5];
        tags = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        rst = 1'b1; out_ready = 1'b0; clear_overflow = 1'b0;
        idle_bus();
        step(); step();
        rst = 1'b0;

        // Idle bus with floated values
        for (int i = 0; i < 10; i++) step();
        chk("idle_level", {61'd0, level}, 64'd0);
        chk("idle_valid", {63'd0, out_valid}, 64'd0);
        chk("idle_data", out_data, 64'd0);
        chk("idle_ovf", {63'd0, overflow}, 64'd0);
        chk("idle_stall", {63'd0, bus_stall}, 64'd0);

        // Tag filter with one-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, tags[i], 64'hA0 + 64'(i));
            if (tags[i] == 2'd1) exp_q.push_back({2'd1, 64'hA0 + 64'(i)});
            step();
            if (tags[i] == 2'd1) begin
                chk("lat_valid", {63'd0, out_valid}, 64'd1);
                chk("lat_data", out_data, 64'hA0 + 64'(i));
            end
        end
        idle_bus();
        step(); step();
        chk("filter_level", {61'd0, level}, 64'd0);

        // Fill, stall, overflow drop, drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd1, 64'h10 + 64'(i));
            if (i < 4) exp_q.push_back({2'd1, 64'h10 + 64'(i)});
            step();
            if (i == 2) chk("stall_lo", {63'd0, bus_stall}, 64'd0);
            if (i == 3) chk("stall_hi", {63'd0, bus_stall}, 64'd1);
        end
        chk("ovf_set", {63'd0, overflow}, 64'd1);
        chk("drop_1", {56'd0, drop_count}, 64'd1);
        chk("full_level", {61'd0, level}, 64'd4);
        idle_bus();
        out_ready = 1'b1;
        step();
        chk("stall_fall", {63'd0, bus_stall}, 64'd0);
        for (int i = 0; i < 3; i++) step();
        chk("drain_level", {61'd0, level}, 64'd0);

        // Full FIFO: simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd1, 64'h20 + 64'(i));
            exp_q.push_back({2'd1, 64'h20 + 64'(i)});
            step();
        end
        drive(1'b1, 2'd1, 64'h24);
        exp_q.push_back({2'd1, 64'h24});
        out_ready = 1'b1;
        step();
        chk("pp_level", {61'd0, level}, 64'd4);
        chk("pp_drops", {56'd0, drop_count}, 64'd1);
        chk("pp_head", out_data, 64'h21);
        idle_bus();
        for (int i = 0; i < 4; i++) step();
        chk("pp_drain", {61'd0, level}, 64'd0);

        // Saturation and clear-wins-over-drop
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        chk("clr_cnt", {56'd0, drop_count}, 64'd0);
        chk("clr_ovf", {63'd0, overflow}, 64'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd1, 64'h30 + 64'(i));
            exp_q.push_back({2'd1, 64'h30 + 64'(i)});
            step();
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd1, 64'h1000 + 64'(i));
            step();
            if (i == 254) chk("cnt_255", {56'd0, drop_count}, 64'd255);
        end
        chk("cnt_sat", {56'd0, drop_count}, 64'd255);
        chk("sat_ovf", {63'd0, overflow}, 64'd1);
        drive(1'b1, 2'd1, 64'hDEAD);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        chk("clrw_cnt", {56'd0, drop_count}, 64'd0);
        chk("clrw_ovf", {63'd0, overflow}, 64'd0);
        chk("clrw_level", {61'd0, level}, 64'd4);
        chk("clrw_head", out_data, 64'h30);
        idle_bus();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Asynchronous reset with three words buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd1, 64'h50 + 64'(i));
            step();
        end
        idle_bus();
        chk("pre_rst_level", {61'd0, level}, 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst_level", {61'd0, level}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_stall", {63'd0, bus_stall}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("post_rst_level", {61'd0, level}, 64'd0);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
